// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU with a 16-entry register window.
// Each instruction takes FETCH -> EXEC -> WB. EXEC registers the ALU result,
// carry and branch decision; WB commits ACC, flags, register file and PC.
// HLT parks the core in HALT until reset.
module acc_cpu_core #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 16,
    parameter int PC_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [7:0]        instruction,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry,
    output logic              zero,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // The operand field can name 16 registers; only the first REG_CNT exist.
    localparam int         REG_MAX   = 16;
    localparam logic [4:0] REG_CNT_C = 5'(REG_CNT);

    state_t              state_r;
    state_t              next_state_s;
    logic [PC_W-1:0]     pc_r;
    logic [7:0]          ir_r;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   regs_r [REG_MAX];
    logic                carry_r;
    logic                zero_r;
    logic                halted_r;
    logic                req_r;
    logic [DATA_W-1:0]   alu_res_r;
    logic                alu_carry_r;
    logic                branch_r;

    logic [3:0]          opcode_s;
    logic [3:0]          operand_s;
    logic                fetch_hs_s;
    logic                reg_in_range_s;
    logic [DATA_W-1:0]   reg_rd_s;
    logic [DATA_W-1:0]   imm_ext_s;
    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_carry_s;
    logic                branch_s;
    logic                wr_acc_s;
    logic                wr_carry_s;
    logic                wr_reg_s;
    logic [PC_W-1:0]     jump_off_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     pc_jump_s;

    assign opcode_s       = ir_r[7:4];
    assign operand_s      = ir_r[3:0];
    assign fetch_hs_s     = (state_r == ST_FETCH) && req_r && instr_valid;
    assign reg_in_range_s = ({1'b0, operand_s} < REG_CNT_C);
    assign imm_ext_s      = DATA_W'(operand_s);
    assign jump_off_s     = PC_W'($signed(operand_s));
    assign pc_inc_s       = pc_r + PC_W'(1);
    assign pc_jump_s      = pc_inc_s + jump_off_s;

    assign instr_req  = req_r;
    assign instr_addr = pc_r;
    assign acc_out    = acc_r;
    assign carry      = carry_r;
    assign zero       = zero_r;
    assign halted     = halted_r;

    // Next-state logic: fetch waits for the bus, EXEC/WB are single cycles, HLT parks
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (fetch_hs_s) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC: next_state_s = ST_WB;
            ST_WB: begin
                if (opcode_s == OP_HLT) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_FETCH;
        endcase
    end

    // Register-file read; operands beyond the implemented registers read as zero
    always_comb begin
        reg_rd_s = {DATA_W{1'b0}};
        if (reg_in_range_s) begin
            reg_rd_s = regs_r[operand_s];
        end else begin
            reg_rd_s = {DATA_W{1'b0}};
        end
    end

    // ALU: result and carry for the instruction in IR; unaffected ops keep ACC and C
    always_comb begin
        sum_s       = {1'b0, acc_r} + {1'b0, reg_rd_s};
        diff_s      = {1'b0, acc_r} - {1'b0, reg_rd_s};
        alu_res_s   = acc_r;
        alu_carry_s = carry_r;
        case (opcode_s)
            OP_LDI: alu_res_s = imm_ext_s;
            OP_LDR: alu_res_s = reg_rd_s;
            OP_ADD: begin
                alu_res_s   = sum_s[DATA_W-1:0];
                alu_carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                alu_res_s   = diff_s[DATA_W-1:0];
                alu_carry_s = diff_s[DATA_W];
            end
            OP_AND: alu_res_s = acc_r & reg_rd_s;
            OP_OR:  alu_res_s = acc_r | reg_rd_s;
            OP_XOR: alu_res_s = acc_r ^ reg_rd_s;
            OP_SHL: begin
                alu_res_s   = {acc_r[DATA_W-2:0], 1'b0};
                alu_carry_s = acc_r[DATA_W-1];
            end
            OP_SHR: begin
                alu_res_s   = {1'b0, acc_r[DATA_W-1:1]};
                alu_carry_s = acc_r[0];
            end
            OP_ADDI: begin
                sum_s       = {1'b0, acc_r} + {1'b0, imm_ext_s};
                alu_res_s   = sum_s[DATA_W-1:0];
                alu_carry_s = sum_s[DATA_W];
            end
            default: begin
                alu_res_s   = acc_r;
                alu_carry_s = carry_r;
            end
        endcase
    end

    // Branch decision from the current flags
    always_comb begin
        branch_s = 1'b0;
        case (opcode_s)
            OP_JZ:   branch_s = zero_r;
            OP_JC:   branch_s = carry_r;
            OP_JMP:  branch_s = 1'b1;
            default: branch_s = 1'b0;
        endcase
    end

    // Write-back enables: which architectural state the instruction updates
    always_comb begin
        wr_acc_s   = 1'b0;
        wr_carry_s = 1'b0;
        wr_reg_s   = 1'b0;
        case (opcode_s)
            OP_LDI, OP_LDR, OP_AND, OP_OR, OP_XOR: wr_acc_s = 1'b1;
            OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ADDI: begin
                wr_acc_s   = 1'b1;
                wr_carry_s = 1'b1;
            end
            OP_STR:  wr_reg_s = reg_in_range_s;
            default: begin
                wr_acc_s   = 1'b0;
                wr_carry_s = 1'b0;
                wr_reg_s   = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus request and halt indication, registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_r    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            req_r    <= (next_state_s == ST_FETCH);
            halted_r <= (next_state_s == ST_HALT);
        end
    end

    // Instruction register: loaded only on an accepted fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_r <= 8'h00;
        end else if (fetch_hs_s) begin
            ir_r <= instruction;
        end
    end

    // EXEC stage: capture ALU result, next carry and branch decision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_res_r   <= {DATA_W{1'b0}};
            alu_carry_r <= 1'b0;
            branch_r    <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            alu_res_r   <= alu_res_s;
            alu_carry_r <= alu_carry_s;
            branch_r    <= branch_s;
        end
    end

    // WB stage: commit ACC, flags and PC; HLT keeps PC on itself
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r   <= {DATA_W{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            pc_r    <= {PC_W{1'b0}};
        end else if (state_r == ST_WB) begin
            if (wr_acc_s) begin
                acc_r  <= alu_res_r;
                zero_r <= (alu_res_r == {DATA_W{1'b0}});
            end
            if (wr_carry_s) begin
                carry_r <= alu_carry_r;
            end
            if (opcode_s == OP_HLT) begin
                pc_r <= pc_r;
            end else if (branch_r) begin
                pc_r <= pc_jump_s;
            end else begin
                pc_r <= pc_inc_s;
            end
        end
    end

    // Register file: STR stores ACC into an implemented register during WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_MAX; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if ((state_r == ST_WB) && wr_reg_s) begin
            regs_r[operand_s] <= acc_r;
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core. Stimulus pushes the expected architectural
// state for every committed instruction; monitors pop and compare whenever a
// core re-raises instr_req (next fetch) or raises halted.
module tb_acc_cpu_core;

    typedef struct packed {
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic [7:0] addr;
        logic       h;
        logic [7:0] gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic       instr_valid;
    logic [7:0] instruction, instruction1;
    logic       req0, req1, carry0, carry1, zero0, zero1, halted0, halted1;
    logic [7:0] addr0, addr1, acc0, acc1;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_fail = 0;
    int         stall_left = 0;
    logic       stall_active = 1'b0;
    logic [7:0] stall_pc = 8'h00;
    logic [7:0] stall_acc = 8'h00;

    always #5 clk = ~clk;

    acc_cpu_core #(.DATA_W(8), .REG_CNT(16), .PC_W(8)) dut0 (
        .clk(clk), .reset(rst0), .instr_req(req0), .instr_addr(addr0),
        .instr_valid(instr_valid), .instruction(instruction), .acc_out(acc0),
        .carry(carry0), .zero(zero0), .halted(halted0)
    );

    acc_cpu_core #(.DATA_W(8), .REG_CNT(4), .PC_W(8)) dut1 (
        .clk(clk), .reset(rst1), .instr_req(req1), .instr_addr(addr1),
        .instr_valid(instr_valid), .instruction(instruction1), .acc_out(acc1),
        .carry(carry1), .zero(zero1), .halted(halted1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_evt(input string tag, input exp_t e, input logic [7:0] acc,
                               input logic c, input logic z, input logic [7:0] addr,
                               input logic h, input int gap);
        check({tag, ".acc"}, 32'(acc), 32'(e.acc));
        check({tag, ".carry"}, 32'(c), 32'(e.c));
        check({tag, ".zero"}, 32'(z), 32'(e.z));
        check({tag, ".addr"}, 32'(addr), 32'(e.addr));
        check({tag, ".halted"}, 32'(h), 32'(e.h));
        if (e.gap != 8'd0) begin
            check({tag, ".cycles"}, 32'(gap), 32'(e.gap));
        end
    endtask

    task automatic push(input bit which, input logic [7:0] acc, input logic c, input logic z,
                        input logic [7:0] addr, input logic h, input logic [7:0] gap);
        exp_t e;
        e.acc = acc; e.c = c; e.z = z; e.addr = addr; e.h = h; e.gap = gap;
        if (which) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Monitor for the REG_CNT=16 core
    int   cnt0 = 0, last0 = 0, ev0 = 0;
    logic prev_req0 = 1'b0, prev_h0 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if ((req0 && !prev_req0) || (halted0 && !prev_h0)) begin
            if (q0.size() == 0) begin
                check($sformatf("dut0.unexpected_commit%0d", ev0), 32'(addr0), 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                compare_evt($sformatf("dut0.evt%0d", ev0), e, acc0, carry0, zero0, addr0, halted0, cnt0 - last0);
            end
            ev0 <= ev0 + 1;
            last0 <= cnt0;
        end
        cnt0 <= cnt0 + 1;
        prev_req0 <= req0;
        prev_h0 <= halted0;
    end

    // Monitor for the REG_CNT=4 core
    int   cnt1 = 0, last1 = 0, ev1 = 0;
    logic prev_req1 = 1'b0, prev_h1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if ((req1 && !prev_req1) || (halted1 && !prev_h1)) begin
            if (q1.size() == 0) begin
                check($sformatf("dut1.unexpected_commit%0d", ev1), 32'(addr1), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                compare_evt($sformatf("dut1.evt%0d", ev1), e, acc1, carry1, zero1, addr1, halted1, cnt1 - last1);
            end
            ev1 <= ev1 + 1;
            last1 <= cnt1;
        end
        cnt1 <= cnt1 + 1;
        prev_req1 <= req1;
        prev_h1 <= halted1;
    end

    task automatic drive();
        if (stall_left > 0 && (stall_active || (req0 && addr0 == stall_pc))) begin
            stall_active = 1'b1;
            stall_left--;
            instr_valid = 1'b0;
            check("stall.req", 32'(req0), 32'd1);
            check("stall.addr", 32'(addr0), 32'(stall_pc));
            check("stall.acc", 32'(acc0), 32'(stall_acc));
            check("stall.flags", 32'({carry0, zero0}), 32'd0);
        end else begin
            instr_valid = 1'b1;
        end
        instruction  = mem[addr0];
        instruction1 = mem[addr1];
    endtask

    task automatic run(input int budget);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < budget) begin
            @(negedge clk); #1;
            drive();
            k++;
        end
        check("timeout.q0_pending", 32'(q0.size()), 32'd0);
        check("timeout.q1_pending", 32'(q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic load(input logic [7:0] prog []);
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    task automatic do_reset(input bit use1);
        @(negedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0; instr_valid = 1'b0;
        stall_left = 0; stall_active = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk); #1;
        check("reset.acc", 32'(acc0), 32'd0);
        check("reset.flags", 32'({carry0, zero0, halted0}), 32'd0);
        check("reset.req", 32'(req0), 32'd0);
        check("reset.addr", 32'(addr0), 32'd0);
        push(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        if (use1) push(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        rst0 = 1'b1;
        rst1 = use1;
    endtask

    task automatic halt_hold(input logic [7:0] pc, input logic [7:0] acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            instr_valid = (i % 2 == 0);
            instruction = 8'h15;
            check("halt.halted", 32'(halted0), 32'd1);
            check("halt.req", 32'(req0), 32'd0);
            check("halt.addr", 32'(addr0), 32'(pc));
            check("halt.acc", 32'(acc0), 32'(acc));
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; instr_valid = 1'b0;
        instruction = 8'h00; instruction1 = 8'h00;

        // LDI 5, ADDI 3, HLT
        load('{8'h15, 8'hE3, 8'hF0});
        do_reset(1'b0);
        push(0, 8'h05, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h08, 0, 0, 8'h02, 0, 8'd3);
        push(0, 8'h08, 0, 0, 8'h02, 1, 8'd3);
        run(200);
        halt_hold(8'h02, 8'h08);

        // LDI F, SHL x4, ADDI F, ADDI 1, STR r2, LDR r2, SHR, HLT
        load('{8'h1F, 8'h90, 8'h90, 8'h90, 8'h90, 8'hEF, 8'hE1, 8'h32, 8'h22, 8'hA0, 8'hF0});
        do_reset(1'b0);
        push(0, 8'h0F, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h1E, 0, 0, 8'h02, 0, 8'd3);
        push(0, 8'h3C, 0, 0, 8'h03, 0, 8'd3);
        push(0, 8'h78, 0, 0, 8'h04, 0, 8'd3);
        push(0, 8'hF0, 0, 0, 8'h05, 0, 8'd3);
        push(0, 8'hFF, 0, 0, 8'h06, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h07, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h08, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h09, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h0A, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h0A, 1, 8'd3);
        run(300);

        // Register ALU ops, SHR carry, JC taken
        load('{8'h16, 8'h31, 8'h13, 8'h51, 8'h41, 8'h61, 8'h71, 8'h81,
               8'hA0, 8'h11, 8'hA0, 8'hC1, 8'hF0, 8'hF0});
        do_reset(1'b0);
        push(0, 8'h06, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h06, 0, 0, 8'h02, 0, 8'd3);
        push(0, 8'h03, 0, 0, 8'h03, 0, 8'd3);
        push(0, 8'hFD, 1, 0, 8'h04, 0, 8'd3);
        push(0, 8'h03, 1, 0, 8'h05, 0, 8'd3);
        push(0, 8'h02, 1, 0, 8'h06, 0, 8'd3);
        push(0, 8'h06, 1, 0, 8'h07, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h08, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h09, 0, 8'd3);
        push(0, 8'h01, 0, 0, 8'h0A, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h0B, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h0D, 0, 8'd3);
        push(0, 8'h00, 1, 1, 8'h0D, 1, 8'd3);
        run(300);

        // JZ not taken, JMP back to 0xFF, JMP 0 wraps, JZ taken to HLT at 3
        load('{8'hB2, 8'h10, 8'hDC, 8'hF0});
        mem[255] = 8'hD0;
        do_reset(1'b0);
        push(0, 8'h00, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h02, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'hFF, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h00, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h03, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h03, 1, 8'd3);
        run(200);
        halt_hold(8'h03, 8'h00);

        // JZ -2 at PC 5: taken with Z=1 (to 4), not taken with Z=0 (to 6)
        load('{8'h10, 8'hD3, 8'hF0, 8'hF0, 8'h12, 8'hBE, 8'hF0});
        do_reset(1'b0);
        push(0, 8'h00, 0, 1, 8'h01, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h05, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h04, 0, 8'd3);
        push(0, 8'h02, 0, 0, 8'h05, 0, 8'd3);
        push(0, 8'h02, 0, 0, 8'h06, 0, 8'd3);
        push(0, 8'h02, 0, 0, 8'h06, 1, 8'd3);
        run(200);

        // Five-cycle fetch stall in front of the HLT at PC 1
        load('{8'h19, 8'hF0});
        do_reset(1'b0);
        stall_pc = 8'h01; stall_acc = 8'h09; stall_left = 5;
        push(0, 8'h09, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h09, 0, 0, 8'h01, 1, 8'd8);
        run(200);
        check("stall.consumed", 32'(stall_left), 32'd0);

        // Reset asserted during EXEC of ADD r3
        load('{8'h15, 8'h33, 8'h43, 8'hF0});
        do_reset(1'b0);
        push(0, 8'h05, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h05, 0, 0, 8'h02, 0, 8'd3);
        run(200);
        @(posedge clk); #2;
        rst0 = 1'b0;
        #1;
        check("midrst.acc", 32'(acc0), 32'd0);
        check("midrst.flags", 32'({carry0, zero0, halted0}), 32'd0);
        check("midrst.req", 32'(req0), 32'd0);
        check("midrst.addr", 32'(addr0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst.acc_held", 32'(acc0), 32'd0);
        // Re-run from 0: ADD r3 must see R3 cleared by the reset
        load('{8'h43, 8'hF0});
        @(negedge clk); #1;
        push(0, 8'h00, 0, 0, 8'h00, 0, 8'd0);
        push(0, 8'h00, 0, 1, 8'h01, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h01, 1, 8'd3);
        rst0 = 1'b1;
        run(200);

        // Out-of-range register on REG_CNT=4 versus in-range on REG_CNT=16
        load('{8'h17, 8'h39, 8'h29, 8'h21, 8'hF0});
        do_reset(1'b1);
        push(1, 8'h07, 0, 0, 8'h01, 0, 8'd3);
        push(1, 8'h07, 0, 0, 8'h02, 0, 8'd3);
        push(1, 8'h00, 0, 1, 8'h03, 0, 8'd3);
        push(1, 8'h00, 0, 1, 8'h04, 0, 8'd3);
        push(1, 8'h00, 0, 1, 8'h04, 1, 8'd3);
        push(0, 8'h07, 0, 0, 8'h01, 0, 8'd3);
        push(0, 8'h07, 0, 0, 8'h02, 0, 8'd3);
        push(0, 8'h07, 0, 0, 8'h03, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h04, 0, 8'd3);
        push(0, 8'h00, 0, 1, 8'h04, 1, 8'd3);
        run(200);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
